vram_line_prefetch: RTL and testbench

//  Burst fetch engine for one 32-bit read-only port of the VRAM interface.
//  - Fetches a run of consecutive 32-bit VRAM words from a start word address.
//  - Buffers the words in a small FIFO.
//  - Delivers them to a downstream line renderer through a valid/ready stream.
//  - Never issues a request the FIFO cannot absorb.
//  - Never leaves a stray duplicate request on the VRAM port.

---
 rtl/vram_line_prefetch.sv | 136 +++++++++++++
 tb/tb_vram_line_prefetch.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_line_prefetch.sv
// vram_line_prefetch: fetches a run of consecutive 32-bit VRAM words into a
// small FIFO and streams them to a line renderer over valid/ready.
// Only one VRAM request is ever outstanding. A new request is issued only
// while the FIFO still has room for the returning word.
module vram_line_prefetch #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [14:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             vram_strobe,
  output logic [14:0]      vram_addr,
  input  logic             vram_ack,
  input  logic [31:0]      vram_rddata,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_SPACE, FINISH} state_t;

  state_t           state_reg;
  logic [14:0]      addr_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic             zero_run_reg;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;

  logic             push;
  logic             pop;
  logic             last_word;
  logic             fifo_full;
  logic [PW:0]      count_next;

  // An ack only counts while a request is actually outstanding; late or stray
  // acks in any other state (including just after reset) are dropped here.
  assign push       = (state_reg == REQ) && vram_ack;
  assign pop        = out_valid && out_ready;
  assign last_word  = (remaining_reg == CNT_W'(1));
  assign fifo_full  = (count_reg == FULL_CNT);
  assign count_next = count_reg + (PW+1)'(push) - (PW+1)'(pop);

  // Strobe drops in the ack cycle so the port never grants the same address twice
  assign vram_strobe = (state_reg == REQ) && !vram_ack;
  assign vram_addr   = addr_reg;
  assign busy        = (state_reg != IDLE);
  // Normal runs flag done on the last ack; empty runs flag it in FINISH
  assign done        = (push && last_word) || ((state_reg == FINISH) && zero_run_reg);

  assign out_valid   = (count_reg != '0);
  assign out_data    = out_valid ? mem[rd_ptr_reg] : '0;

  // Fetch sequencer: latches the run, issues requests, throttles on FIFO space
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      zero_run_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg      <= base_addr;
            remaining_reg <= word_count;
            zero_run_reg  <= (word_count == '0);
            if (word_count == '0)
              state_reg <= FINISH;
            else if (fifo_full)
              state_reg <= WAIT_SPACE;
            else
              state_reg <= REQ;
          end
        end
        REQ: begin
          if (vram_ack) begin
            addr_reg      <= addr_reg + 15'd1;
            remaining_reg <= remaining_reg - CNT_W'(1);
            if (last_word)
              state_reg <= FINISH;
            else if (count_next == FULL_CNT)
              state_reg <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (!fifo_full)
            state_reg <= REQ;
        end
        FINISH: begin
          zero_run_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // FIFO storage: plain write port, head read through out_data
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= vram_rddata;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Overflow guard: the space check must keep pushes away from a full FIFO
  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(push && fifo_full));
  end

endmodule

// File: tb/tb_vram_line_prefetch.sv
// Directed bench for vram_line_prefetch: a small VRAM port model with a
// configurable grant delay, a consumer log, and one task per scenario.
`timescale 1ns/1ps
module tb_vram_line_prefetch;

  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [14:0]      base_addr = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic             busy;
  logic             done;
  logic             vram_strobe;
  logic [14:0]      vram_addr;
  logic             vram_ack = 1'b0;
  logic [31:0]      vram_rddata = '0;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // VRAM port model and logs
  bit          model_en = 1'b0;
  int          stall_cycles = 0;
  int          wait_cnt = 0;
  int          inject_req = 0;
  int          inject_done = 0;
  int          cyc = 0;
  logic [14:0] req_q[$];
  int          ack_cyc_q[$];
  logic [31:0] out_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          idle_cyc = -1;
  logic        busy_prev = 1'b0;
  int          strobe_cnt = 0;

  always #5 clk = ~clk;

  vram_line_prefetch #(.FIFO_DEPTH(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .vram_strobe(vram_strobe), .vram_addr(vram_addr), .vram_ack(vram_ack),
    .vram_rddata(vram_rddata), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  function automatic logic [31:0] word_of(input logic [14:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a, a};
  endfunction

  // Port model: grants after stall_cycles waiting cycles, ack lasts one cycle
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (reset) wait_cnt = 0;
    if (vram_ack) begin
      vram_ack = 1'b0;
    end else if (inject_req != inject_done) begin
      vram_ack = 1'b1;
      vram_rddata = 32'hDEAD_BEEF;
      inject_done++;
    end else if (vram_strobe === 1'b1 && model_en && !reset) begin
      if (wait_cnt >= stall_cycles) begin
        vram_ack = 1'b1;
        vram_rddata = word_of(vram_addr);
        req_q.push_back(vram_addr);
        ack_cyc_q.push_back(cyc);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Consumer / event log sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready) out_q.push_back(out_data);
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (busy_prev && busy === 1'b0) idle_cyc = cyc;
    busy_prev = (busy === 1'b1);
    if (vram_strobe === 1'b1) strobe_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    req_q.delete();
    ack_cyc_q.delete();
    out_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    idle_cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [14:0] b, input logic [CNT_W-1:0] c);
    @(posedge clk); #1;
    base_addr = b; word_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < bound);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (vram_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b required 0", vram_strobe); end
    checks++; if (vram_addr !== 15'h0) begin failures++; $display("FAIL reset_addr: got %h required 0000", vram_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    $display("reset: checks so far %0d", checks);
  endtask

  task automatic test_basic();
    logic [14:0] ea;
    logic [14:0] aa;
    logic [31:0] aw;
    clear_logs();
    model_en = 1'b1; stall_cycles = 0; out_ready = 1'b1;
    pulse_start(15'h0010, CNT_W'(4));
    wait_idle(100, "basic");
    repeat (3) @(negedge clk);
    checks++; if (req_q.size() != 4) begin failures++; $display("FAIL basic_req_count: got %0d required 4", req_q.size()); end
    for (int i = 0; i < 4; i++) begin
      ea = 15'(32'h10 + i);
      aa = (i < req_q.size()) ? req_q[i] : 'x;
      aw = (i < out_q.size()) ? out_q[i] : 'x;
      checks++; if (aa !== ea) begin failures++; $display("FAIL basic_addr[%0d]: got %h required %h", i, aa, ea); end
      checks++; if (aw !== word_of(ea)) begin failures++; $display("FAIL basic_word[%0d]: got %h required %h", i, aw, word_of(ea)); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count: got %0d required 1", done_cnt); end
    checks++;
    if (ack_cyc_q.size() < 4 || done_cyc != ack_cyc_q[3]) begin
      failures++; $display("FAIL basic_done_timing: done cycle %0d, required last ack cycle", done_cyc);
    end
    checks++; if (idle_cyc != done_cyc + 2) begin failures++; $display("FAIL basic_busy_drop: got cycle %0d required %0d", idle_cyc, done_cyc + 2); end
    $display("basic: base=0010 count=4 reqs=%0d words=%0d done_cyc=%0d idle_cyc=%0d", req_q.size(), out_q.size(), done_cyc, idle_cyc);
  endtask

  task automatic test_backpressure();
    int sc;
    logic [14:0] ea;
    logic [14:0] aa;
    logic [31:0] aw;
    clear_logs();
    model_en = 1'b1; stall_cycles = 0; out_ready = 1'b0;
    pulse_start(15'h0100, CNT_W'(12));
    repeat (40) @(negedge clk);
    sc = strobe_cnt;
    repeat (10) @(negedge clk);
    checks++; if (req_q.size() != 8) begin failures++; $display("FAIL bp_full_reqs: got %0d required 8", req_q.size()); end
    checks++; if (strobe_cnt != sc || vram_strobe !== 1'b0) begin failures++; $display("FAIL bp_strobe_idle: strobes %0d->%0d strobe=%b required none", sc, strobe_cnt, vram_strobe); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy: got %b required 1", busy); end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (req_q.size() != 9) begin failures++; $display("FAIL bp_one_more_req: got %0d required 9", req_q.size()); end
    checks++; if (out_q.size() != 1) begin failures++; $display("FAIL bp_one_pop: got %0d required 1", out_q.size()); end
    @(posedge clk); #1; out_ready = 1'b1;
    wait_idle(200, "bp");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      ea = 15'(32'h100 + i);
      aa = (i < req_q.size()) ? req_q[i] : 'x;
      aw = (i < out_q.size()) ? out_q[i] : 'x;
      checks++; if (aa !== ea) begin failures++; $display("FAIL bp_addr[%0d]: got %h required %h", i, aa, ea); end
      checks++; if (aw !== word_of(ea)) begin failures++; $display("FAIL bp_word[%0d]: got %h required %h", i, aw, word_of(ea)); end
    end
    checks++; if (out_q.size() != 12) begin failures++; $display("FAIL bp_word_count: got %0d required 12", out_q.size()); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_count: got %0d required 1", done_cnt); end
    $display("backpressure: base=0100 count=12 reqs=%0d words=%0d", req_q.size(), out_q.size());
  endtask

  task automatic test_stall();
    clear_logs();
    model_en = 1'b1; stall_cycles = 5; out_ready = 1'b1;
    pulse_start(15'h0020, CNT_W'(2));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (vram_strobe !== 1'b1 || vram_addr !== 15'h0020 || vram_ack !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d]: strobe=%b addr=%h required strobe=1 addr=0020", k, vram_strobe, vram_addr);
      end
    end
    @(negedge clk);
    checks++; if (vram_strobe !== 1'b0) begin failures++; $display("FAIL stall_ack_strobe: got %b required 0 in ack cycle", vram_strobe); end
    wait_idle(100, "stall");
    repeat (3) @(negedge clk);
    stall_cycles = 0;
    checks++; if (req_q.size() != 2) begin failures++; $display("FAIL stall_reqs: got %0d required 2", req_q.size()); end
    checks++; if (out_q.size() != 2) begin failures++; $display("FAIL stall_words: got %0d required 2", out_q.size()); end
    checks++;
    if (out_q.size() < 2 || out_q[0] !== word_of(15'h0020) || out_q[1] !== word_of(15'h0021)) begin
      failures++; $display("FAIL stall_data: words out of order or wrong, required %h %h", word_of(15'h0020), word_of(15'h0021));
    end
    $display("stall: base=0020 count=2 stall=5 reqs=%0d words=%0d", req_q.size(), out_q.size());
  endtask

  task automatic test_wrap();
    logic [14:0] exp_a [3];
    logic [14:0] aa;
    logic [31:0] aw;
    exp_a[0] = 15'h7FFE; exp_a[1] = 15'h7FFF; exp_a[2] = 15'h0000;
    clear_logs();
    model_en = 1'b1; stall_cycles = 0; out_ready = 1'b1;
    pulse_start(15'h7FFE, CNT_W'(3));
    wait_idle(100, "wrap");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      aa = (i < req_q.size()) ? req_q[i] : 'x;
      aw = (i < out_q.size()) ? out_q[i] : 'x;
      checks++; if (aa !== exp_a[i]) begin failures++; $display("FAIL wrap_addr[%0d]: got %h required %h", i, aa, exp_a[i]); end
      checks++; if (aw !== word_of(exp_a[i])) begin failures++; $display("FAIL wrap_word[%0d]: got %h required %h", i, aw, word_of(exp_a[i])); end
    end
    $display("wrap: base=7FFE count=3 reqs=%0d words=%0d", req_q.size(), out_q.size());
  endtask

  task automatic test_zero_and_busy_start();
    int sc;
    clear_logs();
    model_en = 1'b1; stall_cycles = 0; out_ready = 1'b1;
    sc = strobe_cnt;
    pulse_start(15'h0055, CNT_W'(0));
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %b required 1", done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy_finish: got %b required 1", busy); end
    checks++; if (vram_addr !== 15'h0055) begin failures++; $display("FAIL zero_addr_latch: got %h required 0055", vram_addr); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_after: done=%b busy=%b required 0 0", done, busy); end
    repeat (3) @(negedge clk);
    checks++; if (strobe_cnt != sc || req_q.size() != 0) begin failures++; $display("FAIL zero_no_strobe: strobes=%0d reqs=%0d required 0 0", strobe_cnt - sc, req_q.size()); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count: got %0d required 1", done_cnt); end

    clear_logs();
    stall_cycles = 3;
    pulse_start(15'h0200, CNT_W'(3));
    pulse_start(15'h0300, CNT_W'(5));
    @(negedge clk);
    checks++; if (vram_addr !== 15'h0200) begin failures++; $display("FAIL busy_start_addr: got %h required 0200", vram_addr); end
    wait_idle(200, "busy_start");
    repeat (3) @(negedge clk);
    stall_cycles = 0;
    checks++; if (req_q.size() != 3) begin failures++; $display("FAIL busy_start_reqs: got %0d required 3", req_q.size()); end
    checks++;
    if (req_q.size() < 3 || req_q[0] !== 15'h0200 || req_q[1] !== 15'h0201 || req_q[2] !== 15'h0202) begin
      failures++; $display("FAIL busy_start_seq: address sequence wrong, required 0200 0201 0202");
    end
    checks++; if (out_q.size() != 3) begin failures++; $display("FAIL busy_start_words: got %0d required 3", out_q.size()); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL busy_start_done: got %0d required 1", done_cnt); end
    $display("zero/busy: zero-run done ok path, ignored start reqs=%0d words=%0d", req_q.size(), out_q.size());
  endtask

  task automatic test_reset_mid_run();
    int n;
    int dc;
    logic [14:0] ea;
    logic [14:0] aa;
    logic [31:0] aw;
    clear_logs();
    model_en = 1'b1; stall_cycles = 0; out_ready = 1'b0;
    pulse_start(15'h0400, CNT_W'(6));
    n = 0;
    do begin @(negedge clk); n++; end while (req_q.size() < 2 && n < 50);
    model_en = 1'b0;
    checks++; if (req_q.size() != 2) begin failures++; $display("FAIL rst_pre_reqs: got %0d required 2", req_q.size()); end
    dc = done_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk); inject_req++;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checks++; if (vram_strobe !== 1'b0) begin failures++; $display("FAIL rst_strobe: got %b required 0", vram_strobe); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_fifo_empty: out_valid=%b required 0", out_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_state: busy=%b done=%b required 0 0", busy, done); end
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_late_ack: out_valid=%b required 0", out_valid); end
    checks++; if (done_cnt != dc) begin failures++; $display("FAIL rst_no_done: got %0d required %0d", done_cnt, dc); end

    clear_logs();
    model_en = 1'b1; out_ready = 1'b1;
    pulse_start(15'h0600, CNT_W'(3));
    wait_idle(100, "rst_restart");
    repeat (3) @(negedge clk);
    checks++; if (out_q.size() != 3) begin failures++; $display("FAIL rst_restart_words: got %0d required 3", out_q.size()); end
    for (int i = 0; i < 3; i++) begin
      ea = 15'(32'h600 + i);
      aa = (i < req_q.size()) ? req_q[i] : 'x;
      aw = (i < out_q.size()) ? out_q[i] : 'x;
      checks++; if (aa !== ea) begin failures++; $display("FAIL rst_restart_addr[%0d]: got %h required %h", i, aa, ea); end
      checks++; if (aw !== word_of(ea)) begin failures++; $display("FAIL rst_restart_word[%0d]: got %h required %h", i, aw, word_of(ea)); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rst_restart_done: got %0d required 1", done_cnt); end
    $display("reset mid-run: restart base=0600 reqs=%0d words=%0d", req_q.size(), out_q.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_wrap();
    test_zero_and_busy_start();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
